// File: rtl/current_filter_pkg.sv
// Shared types and helpers for the current filter frame sequencer.
package current_filter_pkg;

  // Sequencer phases: wait for a tick, gather samples, hand frame to the
  // filter, wait for the filtered result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    WAIT    = 2'd3
  } seq_state_t;

  // Signed a - b clamped to the range of a width-bit two's complement value.
  // Operands arrive sign-extended to 32 bits; the subtraction is done in 33
  // bits so it cannot wrap. Valid for width in 2..31.
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] diff;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    diff  = {a[31], a} - {b[31], b};
    max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (width - 1));
    if (diff > max_v) begin
      return max_v[31:0];
    end else if (diff < min_v) begin
      return min_v[31:0];
    end
    return diff[31:0];
  endfunction

endpackage

// File: rtl/current_offset_sat.sv
// Per-channel offset removal: result = clamp(sample - offset), purely combinational.
module current_offset_sat
  import current_filter_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_sample,
  input  logic [DW-1:0] i_offset,
  output logic [DW-1:0] o_result
);

  logic signed [DW-1:0] w_sample_s;
  logic signed [DW-1:0] w_offset_s;
  logic signed [31:0]   w_sample_x;
  logic signed [31:0]   w_offset_x;

  // Sign-extend both operands and clamp the difference back into DW bits.
  always_comb begin
    w_sample_s = i_sample;
    w_offset_s = i_offset;
    w_sample_x = 32'(w_sample_s);
    w_offset_x = 32'(w_offset_s);
    o_result   = DW'(sat_sub(w_sample_x, w_offset_x, DW));
  end

endmodule

// File: rtl/current_filter_sequencer.sv
// Frame sequencer in front of the shared multi-channel current FIR filter.
// Gathers one offset-corrected sample per channel per frame tick, hands the
// packed frame to the filter and publishes the filtered frame as a strobe.
//
// Handshakes: flt_in_* and flt_out_* are valid/ready pairs; a transfer happens
// on a rising clk edge where valid and ready are both high. flt_in_valid is
// held with stable data until that transfer. out_valid is a one-cycle strobe
// with no backpressure.
module current_filter_sequencer
  import current_filter_pkg::*;
#(
  parameter int  DATA_WIDTH     = 16,
  parameter int  DATA_COUNT     = 2,
  parameter int  TIMEOUT_CYCLES = 64,
  parameter int  OVR_WIDTH      = 8,
  localparam int CH_W           = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1,
  localparam int FW             = DATA_COUNT * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_tick,
  input  logic [FW-1:0]         ch_data,
  input  logic [DATA_COUNT-1:0] ch_valid,
  input  logic                  cfg_write,
  input  logic [CH_W-1:0]       cfg_channel,
  input  logic [DATA_WIDTH-1:0] cfg_offset,
  output logic [FW-1:0]         flt_in_data,
  output logic                  flt_in_valid,
  input  logic                  flt_in_ready,
  input  logic [FW-1:0]         flt_out_data,
  input  logic                  flt_out_valid,
  output logic                  flt_out_ready,
  output logic [FW-1:0]         out_data,
  output logic                  out_valid,
  output logic [DATA_COUNT-1:0] out_stale,
  output logic [OVR_WIDTH-1:0]  overrun_count,
  output logic                  busy,
  output seq_state_t            dbg_state
);

  localparam int               DW         = DATA_WIDTH;
  localparam int               DC         = DATA_COUNT;
  localparam int               TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [TW-1:0]         r_timer;
  logic [DW-1:0]         r_offset [DC];
  logic [DW-1:0]         r_held   [DC];
  logic [DW-1:0]         w_capt   [DC];
  logic [DC-1:0]         r_got;
  logic [DC-1:0]         w_got_nxt;
  logic [DC-1:0]         r_stale;
  logic [FW-1:0]         r_flt_in_data;
  logic [FW-1:0]         r_out_data;
  logic [DC-1:0]         r_out_stale;
  logic                  r_out_valid;
  logic [OVR_WIDTH-1:0]  r_ovr;
  logic                  w_issue_latch;
  logic                  w_in_hs;
  logic                  w_publish;

  // One saturating offset subtractor per channel.
  for (genvar g = 0; g < DC; g++) begin : g_chan
    current_offset_sat #(.DW(DW)) u_sat (
      .i_sample (ch_data[DW*g +: DW]),
      .i_offset (r_offset[g]),
      .o_result (w_capt[g])
    );
  end

  // Offset registers; an index beyond the channel count is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DC; i++) r_offset[i] <= '0;
    end else if (cfg_write && (32'(cfg_channel) < DC)) begin
      r_offset[cfg_channel] <= cfg_offset;
    end
  end

  // Got flags: set by any sample strobe, cleared when a frame is handed off,
  // but a sample landing on the hand-off cycle belongs to the next frame.
  always_comb begin
    w_got_nxt = r_got | ch_valid;
    if (w_in_hs) w_got_nxt = ch_valid;
  end

  // Sample capture runs in every state; offset is applied at capture time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DC; i++) r_held[i] <= '0;
      r_got <= '0;
    end else begin
      for (int i = 0; i < DC; i++) begin
        if (ch_valid[i]) r_held[i] <= w_capt[i];
      end
      r_got <= w_got_nxt;
    end
  end

  // Next-state logic and the one-cycle event strobes of each phase.
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_latch = 1'b0;
    w_in_hs       = 1'b0;
    w_publish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_tick && enable) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        if ((&r_got) || (r_timer == TIMER_LAST)) begin
          w_issue_latch = 1'b1;
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (flt_in_ready) begin
          w_in_hs     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flt_out_valid) begin
          w_publish   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Collect timeout counter: counts cycles spent in COLLECT, zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_timer <= '0;
    else if (r_state == COLLECT) r_timer <= r_timer + TW'(1);
    else                        r_timer <= '0;
  end

  // Frame latch toward the filter: snapshot of held samples and missing channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flt_in_data <= '0;
      r_stale       <= '0;
    end else if (w_issue_latch) begin
      for (int i = 0; i < DC; i++) r_flt_in_data[DW*i +: DW] <= r_held[i];
      r_stale <= ~r_got;
    end
  end

  // Publish the filtered frame with its stale flags as a one-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_stale <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_publish;
      if (w_publish) begin
        r_out_data  <= flt_out_data;
        r_out_stale <= r_stale;
      end
    end
  end

  // Saturating count of ticks that arrive while a frame is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr <= '0;
    end else if (frame_tick && (r_state != IDLE) && (r_ovr != {OVR_WIDTH{1'b1}})) begin
      r_ovr <= r_ovr + OVR_WIDTH'(1);
    end
  end

  assign flt_in_data   = r_flt_in_data;
  assign flt_in_valid  = (r_state == ISSUE);
  assign flt_out_ready = (r_state == WAIT);
  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_stale     = r_out_stale;
  assign overrun_count = r_ovr;
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;

endmodule
